// File: rtl/mmu_csr_pkg.sv
// mmu_csr_pkg: shared constants for the MMU control/status register file.
//   - CSR addresses
//   - field bit positions
//   - writable-bit masks for each register image
//   - exception codes and the TLB-exception ecode classification helpers
package mmu_csr_pkg;

  // CSR addresses
  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_TLBIDX    = 14'h010;
  localparam logic [13:0] CSR_TLBEHI    = 14'h011;
  localparam logic [13:0] CSR_TLBELO0   = 14'h012;
  localparam logic [13:0] CSR_TLBELO1   = 14'h013;
  localparam logic [13:0] CSR_ASID      = 14'h018;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h088;
  localparam logic [13:0] CSR_DMW0      = 14'h180;
  localparam logic [13:0] CSR_DMW1      = 14'h181;

  // Field bit positions
  localparam int CRMD_PLV_LSB    = 0;
  localparam int CRMD_IE_BIT     = 2;
  localparam int CRMD_DA_BIT     = 3;
  localparam int CRMD_PG_BIT     = 4;
  localparam int TLBIDX_PS_LSB   = 24;
  localparam int TLBIDX_PS_MSB   = 29;
  localparam int TLBIDX_NE_BIT   = 31;
  localparam int TLBEHI_VPPN_LSB = 13;
  localparam int ASID_ASIDBITS_LSB = 16;

  // Writable bits of each register image; everything else reads 0
  localparam logic [31:0] CRMD_WMASK      = 32'h0000_01FF;
  localparam logic [31:0] PRMD_WMASK      = 32'h0000_0007;
  localparam logic [31:0] BADV_WMASK      = 32'hFFFF_FFFF;
  localparam logic [31:0] TLBEHI_WMASK    = 32'hFFFF_E000;
  localparam logic [31:0] TLBELO_WMASK    = 32'hFFFF_FF7F;
  localparam logic [31:0] ASID_WMASK      = 32'h0000_03FF;
  localparam logic [31:0] TLBRENTRY_WMASK = 32'hFFFF_FFC0;
  localparam logic [31:0] DMW_WMASK       = 32'hEE00_0039;

  // CRMD after reset: direct-address mode, PLV0, interrupts off
  localparam logic [31:0] CRMD_RESET      = 32'h0000_0008;
  // ASIDBITS is a constant 10 in the ASID image
  localparam logic [31:0] ASID_BITS_IMAGE = 32'd10 << ASID_ASIDBITS_LSB;

  // Exception codes
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  // TLB-related exceptions capture both BADV and TLBEHI.VPPN
  function automatic logic is_tlb_ecode(input logic [5:0] ecode);
    return (ecode == ECODE_TLBR) || (ecode == ECODE_PIL) || (ecode == ECODE_PIS) ||
           (ecode == ECODE_PIF)  || (ecode == ECODE_PME) || (ecode == ECODE_PPI);
  endfunction

  // Address exceptions capture BADV only
  function automatic logic is_addr_ecode(input logic [5:0] ecode);
    return (ecode == ECODE_ADE) || (ecode == ECODE_ALE);
  endfunction

endpackage

// File: rtl/mmu_csr_file.sv
// mmu_csr_file: MMU-related CSR file sitting beside write-back.
// Holds CRMD, PRMD, ESTAT.Ecode, BADV, TLBIDX, TLBEHI, TLBELO0/1, ASID,
// TLBRENTRY and DMW0/1. All updates commit on the clock edge and become
// visible on csr_rvalue and the packed outputs in the following cycle.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   csr_num/csr_rvalue    combinational CSR read
//   csr_we/wmask/wvalue   masked software write
//   wb_ex/wb_ecode/wb_vaddr, ertn   exception entry / return
//   tlbsrch_*, tlbrd_*    TLB instruction results from the MMU
//   crmd..in_tlbr         register fields consumed by the MMU
module mmu_csr_file
  import mmu_csr_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int IDXW  = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [13:0]     csr_num,
  output logic [31:0]     csr_rvalue,
  input  logic            csr_we,
  input  logic [31:0]     csr_wmask,
  input  logic [31:0]     csr_wvalue,
  input  logic            wb_ex,
  input  logic [5:0]      wb_ecode,
  input  logic [31:0]     wb_vaddr,
  input  logic            ertn,
  input  logic            tlbsrch_valid,
  input  logic            tlbsrch_found,
  input  logic [IDXW-1:0] tlbsrch_index,
  input  logic            tlbrd_valid,
  input  logic            tlbrd_e,
  input  logic [18:0]     tlbrd_vppn,
  input  logic [5:0]      tlbrd_ps,
  input  logic [9:0]      tlbrd_asid,
  input  logic [31:0]     tlbrd_elo0,
  input  logic [31:0]     tlbrd_elo1,
  output logic [8:0]      crmd,
  output logic [9:0]      asid,
  output logic [18:0]     tlbehi_vppn,
  output logic [31:0]     tlbidx,
  output logic [31:0]     tlbelo0,
  output logic [31:0]     tlbelo1,
  output logic [31:0]     dmw0,
  output logic [31:0]     dmw1,
  output logic [5:0]      estat_ecode,
  output logic [31:0]     tlbrentry,
  output logic            in_tlbr
);

  localparam logic [31:0] TLBIDX_WMASK = 32'hBF00_0000 | ((32'd1 << IDXW) - 32'd1);

  // Register images: reserved bits are held at zero so reads need no masking
  logic [31:0] crmd_q, prmd_q, badv_q, tlbidx_q, tlbehi_q;
  logic [31:0] elo0_q, elo1_q, asid_q, tlbrentry_q, dmw0_q, dmw1_q;
  logic [5:0]  ecode_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wmask,
                                        input logic [31:0] wvalue, input logic [31:0] writable);
    logic [31:0] m;
    m = wmask & writable;
    return (old & ~m) | (wvalue & m);
  endfunction

  // Single commit point; the if/else chain encodes event priority
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_q      <= CRMD_RESET;
      prmd_q      <= '0;
      ecode_q     <= '0;
      badv_q      <= '0;
      tlbidx_q    <= '0;
      tlbehi_q    <= '0;
      elo0_q      <= '0;
      elo1_q      <= '0;
      asid_q      <= '0;
      tlbrentry_q <= '0;
      dmw0_q      <= '0;
      dmw1_q      <= '0;
    end else if (wb_ex) begin
      prmd_q      <= {29'd0, crmd_q[CRMD_IE_BIT:CRMD_PLV_LSB]};
      crmd_q[CRMD_IE_BIT:CRMD_PLV_LSB] <= 3'b000;
      ecode_q     <= wb_ecode;
      if (wb_ecode == ECODE_TLBR) begin
        // Refill runs untranslated
        crmd_q[CRMD_DA_BIT] <= 1'b1;
        crmd_q[CRMD_PG_BIT] <= 1'b0;
      end
      if (is_tlb_ecode(wb_ecode)) begin
        badv_q   <= wb_vaddr;
        tlbehi_q <= wb_vaddr & TLBEHI_WMASK;
      end else if (is_addr_ecode(wb_ecode)) begin
        badv_q   <= wb_vaddr;
      end
    end else if (ertn) begin
      crmd_q[CRMD_IE_BIT:CRMD_PLV_LSB] <= prmd_q[2:0];
      if (ecode_q == ECODE_TLBR) begin
        crmd_q[CRMD_DA_BIT] <= 1'b0;
        crmd_q[CRMD_PG_BIT] <= 1'b1;
      end
    end else if (tlbrd_valid) begin
      // INDEX is left alone; an empty entry clears everything it would load
      tlbidx_q[TLBIDX_NE_BIT] <= ~tlbrd_e;
      if (tlbrd_e) begin
        tlbidx_q[TLBIDX_PS_MSB:TLBIDX_PS_LSB] <= tlbrd_ps;
        tlbehi_q <= {tlbrd_vppn, 13'd0};
        elo0_q   <= tlbrd_elo0 & TLBELO_WMASK;
        elo1_q   <= tlbrd_elo1 & TLBELO_WMASK;
        asid_q   <= {22'd0, tlbrd_asid};
      end else begin
        tlbidx_q[TLBIDX_PS_MSB:TLBIDX_PS_LSB] <= '0;
        tlbehi_q <= '0;
        elo0_q   <= '0;
        elo1_q   <= '0;
        asid_q   <= '0;
      end
    end else if (tlbsrch_valid) begin
      tlbidx_q[TLBIDX_NE_BIT] <= ~tlbsrch_found;
      if (tlbsrch_found) tlbidx_q[IDXW-1:0] <= tlbsrch_index;
    end else if (csr_we) begin
      case (csr_num)
        CSR_CRMD:      crmd_q      <= merge(crmd_q,      csr_wmask, csr_wvalue, CRMD_WMASK);
        CSR_PRMD:      prmd_q      <= merge(prmd_q,      csr_wmask, csr_wvalue, PRMD_WMASK);
        CSR_BADV:      badv_q      <= merge(badv_q,      csr_wmask, csr_wvalue, BADV_WMASK);
        CSR_TLBIDX:    tlbidx_q    <= merge(tlbidx_q,    csr_wmask, csr_wvalue, TLBIDX_WMASK);
        CSR_TLBEHI:    tlbehi_q    <= merge(tlbehi_q,    csr_wmask, csr_wvalue, TLBEHI_WMASK);
        CSR_TLBELO0:   elo0_q      <= merge(elo0_q,      csr_wmask, csr_wvalue, TLBELO_WMASK);
        CSR_TLBELO1:   elo1_q      <= merge(elo1_q,      csr_wmask, csr_wvalue, TLBELO_WMASK);
        CSR_ASID:      asid_q      <= merge(asid_q,      csr_wmask, csr_wvalue, ASID_WMASK);
        CSR_TLBRENTRY: tlbrentry_q <= merge(tlbrentry_q, csr_wmask, csr_wvalue, TLBRENTRY_WMASK);
        CSR_DMW0:      dmw0_q      <= merge(dmw0_q,      csr_wmask, csr_wvalue, DMW_WMASK);
        CSR_DMW1:      dmw1_q      <= merge(dmw1_q,      csr_wmask, csr_wvalue, DMW_WMASK);
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      CSR_CRMD:      csr_rvalue = crmd_q;
      CSR_PRMD:      csr_rvalue = prmd_q;
      CSR_ESTAT:     csr_rvalue = {10'd0, ecode_q, 16'd0};
      CSR_BADV:      csr_rvalue = badv_q;
      CSR_TLBIDX:    csr_rvalue = tlbidx_q;
      CSR_TLBEHI:    csr_rvalue = tlbehi_q;
      CSR_TLBELO0:   csr_rvalue = elo0_q;
      CSR_TLBELO1:   csr_rvalue = elo1_q;
      CSR_ASID:      csr_rvalue = asid_q | ASID_BITS_IMAGE;
      CSR_TLBRENTRY: csr_rvalue = tlbrentry_q;
      CSR_DMW0:      csr_rvalue = dmw0_q;
      CSR_DMW1:      csr_rvalue = dmw1_q;
      default:       csr_rvalue = '0;
    endcase
  end

  assign crmd        = crmd_q[8:0];
  assign asid        = asid_q[9:0];
  assign tlbehi_vppn = tlbehi_q[31:TLBEHI_VPPN_LSB];
  assign tlbidx      = tlbidx_q;
  assign tlbelo0     = elo0_q;
  assign tlbelo1     = elo1_q;
  assign dmw0        = dmw0_q;
  assign dmw1        = dmw1_q;
  assign estat_ecode = ecode_q;
  assign tlbrentry   = tlbrentry_q;
  assign in_tlbr     = (ecode_q == ECODE_TLBR);

endmodule

// File: tb/tb_mmu_csr_file.sv
module tb_mmu_csr_file;

  logic        clk;
  logic        reset;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [31:0] wb_vaddr;
  logic        ertn;
  logic        tlbsrch_valid, tlbsrch_found;
  logic [3:0]  tlbsrch_index;
  logic        tlbrd_valid, tlbrd_e;
  logic [18:0] tlbrd_vppn;
  logic [5:0]  tlbrd_ps;
  logic [9:0]  tlbrd_asid;
  logic [31:0] tlbrd_elo0, tlbrd_elo1;
  logic [8:0]  crmd;
  logic [9:0]  asid;
  logic [18:0] tlbehi_vppn;
  logic [31:0] tlbidx, tlbelo0, tlbelo1, dmw0, dmw1, tlbrentry;
  logic [5:0]  estat_ecode;
  logic        in_tlbr;

  mmu_csr_file #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_vaddr(wb_vaddr), .ertn(ertn),
    .tlbsrch_valid(tlbsrch_valid), .tlbsrch_found(tlbsrch_found), .tlbsrch_index(tlbsrch_index),
    .tlbrd_valid(tlbrd_valid), .tlbrd_e(tlbrd_e), .tlbrd_vppn(tlbrd_vppn), .tlbrd_ps(tlbrd_ps),
    .tlbrd_asid(tlbrd_asid), .tlbrd_elo0(tlbrd_elo0), .tlbrd_elo1(tlbrd_elo1),
    .crmd(crmd), .asid(asid), .tlbehi_vppn(tlbehi_vppn), .tlbidx(tlbidx),
    .tlbelo0(tlbelo0), .tlbelo1(tlbelo1), .dmw0(dmw0), .dmw1(dmw1),
    .estat_ecode(estat_ecode), .tlbrentry(tlbrentry), .in_tlbr(in_tlbr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    assert (!(tlbrd_valid && tlbsrch_valid)) else $error("tlbrd_valid and tlbsrch_valid both high");

  typedef struct {
    bit        rst, we, ex, ert, srch, found, rd, e;
    bit [13:0] num;
    bit [31:0] wmask, wvalue, vaddr, elo0, elo1;
    bit [5:0]  ecode, ps;
    bit [3:0]  sidx;
    bit [18:0] vppn;
    bit [9:0]  asid;
  } op_t;

  typedef struct {
    bit [13:0]  addr;
    bit [31:0]  rv;
    bit [236:0] outs;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model: architectural fields ----------------
  bit [1:0]  m_plv, m_datf, m_datm, m_pplv;
  bit        m_ie, m_da, m_pg, m_pie, m_ne;
  bit [5:0]  m_ecode, m_ps;
  bit [31:0] m_badv, m_elo0, m_elo1, m_dmw0, m_dmw1;
  bit [3:0]  m_idx;
  bit [18:0] m_vppn;
  bit [9:0]  m_asid;
  bit [25:0] m_tre;

  function automatic bit [31:0] m_rd(input bit [13:0] a);
    case (a)
      14'h000: return {23'd0, m_datm, m_datf, m_pg, m_da, m_ie, m_plv};
      14'h001: return {29'd0, m_pie, m_pplv};
      14'h005: return {10'd0, m_ecode, 16'd0};
      14'h007: return m_badv;
      14'h010: return {m_ne, 1'b0, m_ps, 20'd0, m_idx};
      14'h011: return {m_vppn, 13'd0};
      14'h012: return {m_elo0[31:8], 1'b0, m_elo0[6:0]};
      14'h013: return {m_elo1[31:8], 1'b0, m_elo1[6:0]};
      14'h018: return {8'd0, 8'd10, 6'd0, m_asid};
      14'h088: return {m_tre, 6'd0};
      14'h180: return {m_dmw0[31:29], 1'b0, m_dmw0[27:25], 19'd0, m_dmw0[5:4], m_dmw0[3], 2'b0, m_dmw0[0]};
      14'h181: return {m_dmw1[31:29], 1'b0, m_dmw1[27:25], 19'd0, m_dmw1[5:4], m_dmw1[3], 2'b0, m_dmw1[0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_write(input bit [13:0] a, input bit [31:0] v);
    case (a)
      14'h000: {m_datm, m_datf, m_pg, m_da, m_ie, m_plv} = v[8:0];
      14'h001: {m_pie, m_pplv} = v[2:0];
      14'h007: m_badv = v;
      14'h010: begin m_idx = v[3:0]; m_ps = v[29:24]; m_ne = v[31]; end
      14'h011: m_vppn = v[31:13];
      14'h012: m_elo0 = v;
      14'h013: m_elo1 = v;
      14'h018: m_asid = v[9:0];
      14'h088: m_tre = v[31:6];
      14'h180: m_dmw0 = v;
      14'h181: m_dmw1 = v;
      default: ;
    endcase
  endfunction

  function automatic void m_reset();
    {m_datm, m_datf, m_pg, m_ie, m_plv} = '0;
    m_da = 1'b1;
    {m_pplv, m_pie, m_ecode, m_badv, m_idx, m_ps, m_ne, m_vppn} = '0;
    {m_elo0, m_elo1, m_asid, m_tre, m_dmw0, m_dmw1} = '0;
  endfunction

  function automatic void m_apply(input op_t o);
    bit [31:0] img;
    if (o.rst) m_reset();
    else if (o.ex) begin
      m_pplv = m_plv; m_pie = m_ie; m_plv = 0; m_ie = 0; m_ecode = o.ecode;
      if (o.ecode == 6'h3F) begin m_da = 1; m_pg = 0; end
      if (o.ecode inside {6'h3F, 6'h1, 6'h2, 6'h3, 6'h4, 6'h7}) begin
        m_badv = o.vaddr; m_vppn = o.vaddr[31:13];
      end else if (o.ecode inside {6'h8, 6'h9}) m_badv = o.vaddr;
    end else if (o.ert) begin
      m_plv = m_pplv; m_ie = m_pie;
      if (m_ecode == 6'h3F) begin m_da = 0; m_pg = 1; end
    end else if (o.rd) begin
      if (o.e) begin
        m_vppn = o.vppn; m_ps = o.ps; m_elo0 = o.elo0; m_elo1 = o.elo1; m_asid = o.asid; m_ne = 0;
      end else begin
        m_ne = 1; m_vppn = 0; m_ps = 0; m_elo0 = 0; m_elo1 = 0; m_asid = 0;
      end
    end else if (o.srch) begin
      if (o.found) begin m_ne = 0; m_idx = o.sidx; end
      else m_ne = 1;
    end else if (o.we) begin
      img = m_rd(o.num);
      m_write(o.num, (img & ~o.wmask) | (o.wvalue & o.wmask));
    end
  endfunction

  function automatic bit [236:0] m_outs();
    bit [31:0] c, a, h;
    c = m_rd(14'h000); a = m_rd(14'h018); h = m_rd(14'h011);
    return {c[8:0], a[9:0], h[31:13], m_rd(14'h010), m_rd(14'h012), m_rd(14'h013),
            m_rd(14'h180), m_rd(14'h181), m_ecode, m_rd(14'h088), (m_ecode == 6'h3F)};
  endfunction

  // ---------------- stimulus ----------------
  function automatic op_t idle_op(input bit [13:0] a);
    op_t o;
    o = '{default: 0};
    o.num = a;
    return o;
  endfunction

  task automatic step(input op_t o, input bit chk, input bit use_const, input bit [31:0] cval);
    exp_t x;
    reset = o.rst; csr_num = o.num; csr_we = o.we; csr_wmask = o.wmask; csr_wvalue = o.wvalue;
    wb_ex = o.ex; wb_ecode = o.ecode; wb_vaddr = o.vaddr; ertn = o.ert;
    tlbsrch_valid = o.srch; tlbsrch_found = o.found; tlbsrch_index = o.sidx;
    tlbrd_valid = o.rd; tlbrd_e = o.e; tlbrd_vppn = o.vppn; tlbrd_ps = o.ps;
    tlbrd_asid = o.asid; tlbrd_elo0 = o.elo0; tlbrd_elo1 = o.elo1;
    if (chk) begin
      x.addr = o.num;
      x.rv   = use_const ? cval : m_rd(o.num);
      x.outs = m_outs();
      sb.push_back(x);
    end
    m_apply(o);
    @(posedge clk);
    #1;
  endtask

  task automatic rd_expect(input bit [13:0] a, input bit [31:0] v);
    step(idle_op(a), 1'b1, 1'b1, v);
  endtask

  task automatic wr(input bit [13:0] a, input bit [31:0] v, input bit [31:0] m);
    op_t o;
    o = idle_op(a); o.we = 1; o.wvalue = v; o.wmask = m;
    step(o, 1'b1, 1'b0, 32'd0);
  endtask

  function automatic op_t rand_op();
    op_t o;
    bit [13:0] addrs[13] = '{14'h000, 14'h001, 14'h005, 14'h007, 14'h010, 14'h011, 14'h012,
                             14'h013, 14'h018, 14'h088, 14'h180, 14'h181, 14'h3FF};
    bit [5:0] ecodes[9] = '{6'h3F, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h09, 6'h0B};
    o = idle_op(addrs[$urandom_range(0, 12)]);
    o.rst    = ($urandom_range(0, 99) < 2);
    o.we     = $urandom_range(0, 1);
    o.wmask  = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
    o.wvalue = $urandom;
    o.ex     = ($urandom_range(0, 99) < 10);
    o.ecode  = ecodes[$urandom_range(0, 8)];
    o.vaddr  = $urandom;
    o.ert    = ($urandom_range(0, 99) < 8);
    case ($urandom_range(0, 4))
      0: o.rd = 1;
      1: o.srch = 1;
      default: ;
    endcase
    o.found = $urandom_range(0, 1); o.sidx = 4'($urandom);
    o.e = $urandom_range(0, 1); o.vppn = 19'($urandom); o.ps = 6'($urandom);
    o.asid = 10'($urandom); o.elo0 = $urandom; o.elo1 = $urandom;
    return o;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t x;
      logic [236:0] act;
      x = sb.pop_front();
      act = {crmd, asid, tlbehi_vppn, tlbidx, tlbelo0, tlbelo1, dmw0, dmw1,
             estat_ecode, tlbrentry, in_tlbr};
      n_checks++;
      if (csr_rvalue === x.rv) n_pass++;
      else $display("FAIL rvalue addr=%h got=%h want=%h", x.addr, csr_rvalue, x.rv);
      n_checks++;
      if (act === x.outs) n_pass++;
      else $display("FAIL outputs got=%h want=%h", act, x.outs);
    end
  end

  initial begin
    op_t o;
    o = idle_op(14'h0); o.rst = 1;
    step(o, 1'b0, 1'b0, 32'd0);
    step(o, 1'b0, 1'b0, 32'd0);

    // reset state
    rd_expect(14'h000, 32'h0000_0008);
    rd_expect(14'h018, 32'h000A_0000);
    foreach (o.elo0[i]) ; // no-op keeps o in scope usage simple
    rd_expect(14'h001, 0); rd_expect(14'h005, 0); rd_expect(14'h007, 0);
    rd_expect(14'h010, 0); rd_expect(14'h011, 0); rd_expect(14'h012, 0);
    rd_expect(14'h013, 0); rd_expect(14'h088, 0); rd_expect(14'h180, 0);
    rd_expect(14'h181, 0); rd_expect(14'h3FFF, 0);

    // masked write to TLBEHI
    wr(14'h011, 32'hFFFF_FFFF, 32'hFFFF_E000);
    rd_expect(14'h011, 32'hFFFF_E000);

    // TLB refill exception and return
    wr(14'h000, 32'h0000_0017, 32'h0000_01FF);
    o = idle_op(14'h000); o.ex = 1; o.ecode = 6'h3F; o.vaddr = 32'h1234_5678;
    step(o, 1'b1, 1'b0, 32'd0);
    rd_expect(14'h000, 32'h0000_0008);
    rd_expect(14'h001, 32'h0000_0007);
    rd_expect(14'h007, 32'h1234_5678);
    rd_expect(14'h011, 32'h1234_4000);
    rd_expect(14'h005, 32'h003F_0000);
    o = idle_op(14'h000); o.ert = 1;
    step(o, 1'b1, 1'b0, 32'd0);
    rd_expect(14'h000, 32'h0000_0017);
    rd_expect(14'h005, 32'h003F_0000);

    // TLBSRCH hit then miss
    o = idle_op(14'h010); o.srch = 1; o.found = 1; o.sidx = 4'd5;
    step(o, 1'b1, 1'b0, 32'd0);
    rd_expect(14'h010, 32'h0000_0005);
    o = idle_op(14'h010); o.srch = 1; o.found = 0; o.sidx = 4'd9;
    step(o, 1'b1, 1'b0, 32'd0);
    rd_expect(14'h010, 32'h8000_0005);

    // TLBRD valid entry then empty entry
    o = idle_op(14'h010); o.rd = 1; o.e = 1; o.vppn = 19'h1; o.ps = 6'd12; o.asid = 10'd3;
    o.elo0 = 32'h1234_5647; o.elo1 = 32'h0000_00FF;
    step(o, 1'b1, 1'b0, 32'd0);
    rd_expect(14'h010, 32'h0C00_0005);
    rd_expect(14'h018, 32'h000A_0003);
    rd_expect(14'h012, 32'h1234_5647);
    rd_expect(14'h013, 32'h0000_007F);
    rd_expect(14'h011, 32'h0000_2000);
    o = idle_op(14'h010); o.rd = 1; o.e = 0; o.vppn = 19'h7; o.elo0 = 32'hFFFF_FFFF;
    step(o, 1'b1, 1'b0, 32'd0);
    rd_expect(14'h010, 32'h8000_0005);
    rd_expect(14'h012, 0); rd_expect(14'h013, 0);
    rd_expect(14'h011, 0); rd_expect(14'h018, 32'h000A_0000);

    // write dropped by a same-cycle ADE exception
    wr(14'h011, 32'hABCD_E000, 32'hFFFF_FFFF);
    o = idle_op(14'h180); o.we = 1; o.wvalue = 32'hFFFF_FFFF; o.wmask = 32'hFFFF_FFFF;
    o.ex = 1; o.ecode = 6'h08; o.vaddr = 32'hDEAD_BEEF;
    step(o, 1'b1, 1'b0, 32'd0);
    rd_expect(14'h180, 0);
    rd_expect(14'h007, 32'hDEAD_BEEF);
    rd_expect(14'h011, 32'hABCD_E000);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) step(rand_op(), 1'b1, 1'b0, 32'd0);

    step(idle_op(14'h0), 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmu_csr_file.md
Name: mmu_csr_file

Overview:
- Responder side of the MMU/CSR interface. Holds every MMU-related control/status register and drives the packed CSR fields the MMU consumes.
- Applies state updates on these events:
  - TLBSRCH and TLBRD results returned by the MMU.
  - Write-back exceptions and ERTN.
  - CSRWR/CSRXCHG.
- Sits beside the write-back stage; all updates commit at WB.

Parameters:
TLBNUM, 16, TLB entry count; IDXW = clog2(TLBNUM) sizes the TLBIDX.INDEX field.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
csr_num  in  14  CSR address for read and write
csr_rvalue  out  32  combinational read data
csr_we  in  1  CSR write strobe
csr_wmask  in  32  per-bit write mask
csr_wvalue  in  32  write data
wb_ex  in  1  exception commits this cycle
wb_ecode  in  6  exception code
wb_vaddr  in  32  faulting virtual address
ertn  in  1  ERTN commits this cycle
tlbsrch_valid  in  1  TLBSRCH result valid
tlbsrch_found  in  1  search hit
tlbsrch_index  in  IDXW  hit index
tlbrd_valid  in  1  TLBRD result valid
tlbrd_e  in  1  read entry exists
tlbrd_vppn  in  19  entry VPPN
tlbrd_ps  in  6  entry page size
tlbrd_asid  in  10  entry ASID
tlbrd_elo0  in  32  entry lo0 in TLBELO format (G already merged)
tlbrd_elo1  in  32  entry lo1 in TLBELO format
crmd  out  9  {DATM,DATF,PG,DA,IE,PLV}
asid  out  10  ASID.ASID
tlbehi_vppn  out  19  TLBEHI.VPPN
tlbidx  out  32  TLBIDX register image
tlbelo0  out  32  TLBELO0 image
tlbelo1  out  32  TLBELO1 image
dmw0  out  32  DMW0 image
dmw1  out  32  DMW1 image
estat_ecode  out  6  ESTAT.Ecode
tlbrentry  out  32  refill entry address
in_tlbr  out  1  ESTAT.Ecode == 0x3F

Behaviour:

CSR map and fields:
- CRMD 0x0: PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7].
- PRMD 0x1: PPLV[1:0], PIE[2].
- ESTAT 0x5: Ecode[21:16], read-only to software.
- BADV 0x7.
- TLBIDX 0x10: INDEX[IDXW-1:0], PS[29:24], NE[31].
- TLBEHI 0x11: VPPN[31:13].
- TLBELO0/1 0x12/0x13: V0, D1, PLV[3:2], MAT[5:4], G6, PPN[31:8].
- ASID 0x18: ASID[9:0]; ASIDBITS[23:16] reads as constant 10.
- TLBRENTRY 0x88: [31:6].
- DMW0/1 0x180/0x181: PLV0[0], PLV3[3], MAT[5:4], PSEG[27:25], VSEG[31:29].

Reads and writes:
- Reserved bits and unknown addresses read 0.
- Write: field <= (old & ~wmask) | (wvalue & wmask), writable bits only.
- All updates are visible on outputs the cycle after the commit; no bypass.

Reset:
- CRMD = 0x008 (PLV0, IE0, DA1, PG0).
- All other registers 0, outputs follow, in_tlbr = 0.

Commit priority per cycle: reset > wb_ex > ertn > tlbrd_valid/tlbsrch_valid > csr_we. Lower-priority events in the same cycle are dropped.

wb_ex:
- PRMD <= {CRMD.IE, CRMD.PLV}; CRMD.PLV <= 0, CRMD.IE <= 0; ESTAT.Ecode <= wb_ecode.
- Ecode 0x3F: additionally DA <= 1, PG <= 0.
- Ecodes {0x3F, 0x1 PIL, 0x2 PIS, 0x3 PIF, 0x4 PME, 0x7 PPI}: BADV <= wb_vaddr and TLBEHI.VPPN <= wb_vaddr[31:13].
- Ecodes 0x8 ADE and 0x9 ALE: BADV only.

ertn:
- CRMD.PLV/IE <= PRMD.PPLV/PIE.
- If ESTAT.Ecode == 0x3F: DA <= 0, PG <= 1.
- ESTAT is unchanged.

TLBSRCH:
- Found: NE <= 0, INDEX <= tlbsrch_index.
- Not found: NE <= 1, INDEX unchanged.

TLBRD:
- e = 1: TLBEHI.VPPN, PS, ELO0, ELO1 and ASID.ASID load from the tlbrd_* inputs; NE <= 0.
- e = 0: NE <= 1; TLBEHI, PS, ELO0, ELO1 and ASID.ASID all cleared.
- INDEX is never changed by TLBRD.

Protocol rule: tlbrd_valid and tlbsrch_valid are never both high; the bench asserts this.

Decomposition:
- Package mmu_csr_pkg holds:
  - CSR address constants.
  - Field bit-position localparams.
  - Ecode constants (ECODE_TLBR = 0x3F, PIL, PIS, PIF, PME, PPI, ADE, ALE).
  - The TLB-exception ecode set.
- No sub-module is needed. The read mux is one case statement inside the block.

Test Plan:
- Reset, then read CRMD -> 0x00000008; read ASID -> 0x000A0000; all other CSRs read 0.
- Write TLBEHI with wvalue 0xFFFFFFFF, mask 0xFFFFE000 -> reads 0xFFFFE000; next cycle tlbehi_vppn = 0x7FFFF.
- With CRMD PLV3/IE1 (0x7), PG=1, DA=0: wb_ex with ecode 0x3F and vaddr 0x12345678 -> CRMD = 0x008, PRMD = 0x7, BADV = 0x12345678, VPPN = 0x091A2, in_tlbr = 1. Then ertn -> CRMD = 0x017, in_tlbr stays 1.
- tlbsrch found with index 5 -> TLBIDX = 0x00000005. Then not found -> 0x80000005.
- tlbrd e=1 with vppn 0x1, ps 12, asid 3, elo0 0x1234_5647 -> TLBIDX[29:24] = 12, NE = 0, asid = 3, TLBELO0 = 0x12345647. Then tlbrd e=0 -> NE = 1, ELO0/ELO1/VPPN/ASID = 0.
- csr_we to DMW0 together with wb_ex ecode 0x8 -> DMW0 unchanged, BADV updated, TLBEHI unchanged.
